adc_control: RTL and testbench

- Serial ADC readout controller on the EBI command bus; the read-side counterpart of the DAC controller.
- A bus write issues one 16-bit SPI frame to the ADC:
  - the control word (channel select, mode) shifts out on adc_dout;
  - the conversion result shifts in from adc_din at the same time.
- The result is held in a register for the MCU to read back over the command bus.
- SPI clock is divided from ebi_clk; one clock domain only.

---
 rtl/adc_control_pkg.sv | 21 ++
 rtl/adc_spi_shifter.sv | 106 ++++++++++
 rtl/adc_control.sv | 120 ++++++++++++
 tb/tb_adc_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_control_pkg.sv
// Shared definitions for the ADC readout controller: command codes, register
// offsets, the ID word and the frame FSM state encoding.
package adc_control_pkg;

  localparam logic [15:0] ADC_CMD_SAMPLE = 16'd1;
  localparam logic [15:0] ADC_ID         = 16'h0ADC;

  localparam logic [7:0] OFF_ID      = 8'd9;
  localparam logic [7:0] OFF_STATUS  = 8'd10;
  localparam logic [7:0] OFF_RESULT  = 8'd11;
  localparam logic [7:0] OFF_COUNT   = 8'd12;
  localparam logic [7:0] OFF_OVERRUN = 8'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI frame engine for the ADC: sclk divider, bit counter, control-word
// shift-out and result shift-in. One frame is SETUP (CLK_DIV cycles),
// 16 bit periods of 2*CLK_DIV cycles, then HOLD (2*CLK_DIV quiet cycles).
// done pulses for the single cycle whose clock edge enters HOLD, so the
// parent can latch data_in on that same edge.
module adc_spi_shifter
  import adc_control_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        ebi_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] cw,
  output logic        done,
  output logic        busy,
  output logic [15:0] data_in,
  output logic        adc_sclk,
  output logic        adc_ncs,
  output logic        adc_dout,
  input  logic        adc_din
);

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

  adc_state_e  state;
  logic [8:0]  div_cnt;
  logic [3:0]  bit_idx;
  logic [15:0] shift_out;
  logic [15:0] shift_in;

  assign busy    = (state != ST_IDLE);
  assign data_in = shift_in;
  assign done    = (state == ST_SHIFT) && adc_sclk && (div_cnt == 9'd0) && (bit_idx == 4'd0);

  // Frame FSM with registered SPI pins; every phase counts div_cnt down to 0.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge ebi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shift_out <= '0;
      shift_in  <= '0;
      adc_sclk  <= 1'b1;
      adc_ncs   <= 1'b1;
      adc_dout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SETUP;
            div_cnt   <= HALF_LAST;
            bit_idx   <= 4'd15;
            shift_out <= cw;
            shift_in  <= '0;
            adc_ncs   <= 1'b0;
            adc_dout  <= cw[15];
          end
        end
        ST_SETUP: begin
          if (div_cnt == 9'd0) begin
            state    <= ST_SHIFT;
            adc_sclk <= 1'b0;
            div_cnt  <= HALF_LAST;
          end else begin
            div_cnt <= div_cnt - 9'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt != 9'd0) begin
            div_cnt <= div_cnt - 9'd1;
          end else if (!adc_sclk) begin
            // End of low phase: rising sclk, capture the ADC's bit.
            adc_sclk <= 1'b1;
            shift_in <= {shift_in[14:0], adc_din};
            div_cnt  <= HALF_LAST;
          end else if (bit_idx == 4'd0) begin
            state    <= ST_HOLD;
            adc_ncs  <= 1'b1;
            adc_dout <= 1'b0;
            div_cnt  <= HOLD_LAST;
          end else begin
            // End of high phase: falling sclk, present the next control bit.
            adc_sclk  <= 1'b0;
            bit_idx   <= bit_idx - 4'd1;
            shift_out <= {shift_out[14:0], 1'b0};
            adc_dout  <= shift_out[14];
            div_cnt   <= HALF_LAST;
          end
        end
        ST_HOLD: begin
          if (div_cnt == 9'd0) begin
            state <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - 9'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_control.sv
// ADC readout controller on the EBI command bus. A SAMPLE write launches one
// SPI frame; the captured result, a valid flag and a frame counter are read
// back through registered out_data. Optional build macro ADC_OVERRUN_CNT_EN
// adds a saturating counter of SAMPLE writes dropped while busy (offset 13).
module adc_control
  import adc_control_pkg::*;
#(
  parameter int POSITION = 241,
  parameter int CLK_DIV  = 2
) (
  input  logic        ebi_clk,
  input  logic        reset_n,
  input  logic        cmd_bus_enable,
  input  logic        re,
  input  logic        cmd_bus_wr,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  output logic [15:0] out_data,
  output logic        adc_sclk,
  output logic        adc_ncs,
  output logic        adc_dout,
  input  logic        adc_din
);

  logic        cs;
  logic        sample_wr;
  logic        accept;
  logic        rd;
  logic        busy;
  logic        done;
  logic [15:0] shifter_data;
  logic [15:0] result;
  logic        valid;
  logic [15:0] sample_cnt;
  logic [15:0] rd_data;

  assign cs        = cmd_bus_enable && (cmd_bus_addr[15:8] == 8'(POSITION));
  assign sample_wr = cs && cmd_bus_wr && (cmd_bus_data[31:16] == ADC_CMD_SAMPLE);
  assign accept    = sample_wr && !busy;
  assign rd        = cs && re;

  adc_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .ebi_clk  (ebi_clk),
    .reset_n  (reset_n),
    .start    (accept),
    .cw       (cmd_bus_data[15:0]),
    .done     (done),
    .busy     (busy),
    .data_in  (shifter_data),
    .adc_sclk (adc_sclk),
    .adc_ncs  (adc_ncs),
    .adc_dout (adc_dout),
    .adc_din  (adc_din)
  );

`ifdef ADC_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
  logic       overrun_inc;
  logic       overrun_clr;

  assign overrun_inc = sample_wr && busy;
  assign overrun_clr = rd && (cmd_bus_addr[7:0] == OFF_OVERRUN);

  // Saturating overrun counter; a clear coinciding with an increment leaves 1.
  always_ff @(posedge ebi_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (overrun_clr) begin
      overrun_cnt <= overrun_inc ? 8'd1 : 8'd0;
    end else if (overrun_inc && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

  // Result capture, valid flag (set beats clear) and wrapping frame counter.
  // NOTE: every register, including the result holding register, is cleared
  // by reset so an aborted frame can never leave stale data readable.
  always_ff @(posedge ebi_clk or negedge reset_n) begin
    if (!reset_n) begin
      result     <= '0;
      valid      <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (done) begin
        result     <= shifter_data;
        valid      <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
      end else if (rd && (cmd_bus_addr[7:0] == OFF_RESULT)) begin
        valid <= 1'b0;
      end
    end
  end

  // Read-data mux by register offset.
  // NOTE: rd_data gets a default before the case so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (cmd_bus_addr[7:0])
      OFF_ID:     rd_data = ADC_ID;
      OFF_STATUS: rd_data = {14'b0, valid, busy};
      OFF_RESULT: rd_data = result;
      OFF_COUNT:  rd_data = sample_cnt;
`ifdef ADC_OVERRUN_CNT_EN
      OFF_OVERRUN: rd_data = {8'b0, overrun_cnt};
`endif
      default:    rd_data = '0;
    endcase
  end

  // Registered read port; zero whenever no read is addressed to this block.
  always_ff @(posedge ebi_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
    end else begin
      out_data <= rd ? rd_data : 16'h0000;
    end
  end

endmodule

// File: tb/tb_adc_control.sv
// Directed self-checking bench for adc_control (CLK_DIV=2, POSITION=241).
// Inputs change on the falling edge, outputs are checked on the falling edge.
// A small ADC model tracks sclk/ncs on the falling ebi_clk edge, records the
// control word it receives and returns a programmed result MSB first.
module tb_adc_control;

  logic        ebi_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_bus_enable = 1'b0;
  logic        re = 1'b0;
  logic        cmd_bus_wr = 1'b0;
  logic [15:0] cmd_bus_addr = '0;
  logic [31:0] cmd_bus_data = '0;
  logic [15:0] out_data;
  logic        adc_sclk;
  logic        adc_ncs;
  logic        adc_dout;
  logic        adc_din = 1'b0;

  int tests = 0;
  int fails = 0;

  // ADC model state
  logic [15:0] model_res = '0;
  logic [15:0] model_cap = '0;
  int          model_rises = 0;
  int          ncs_low_cnt = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_ncs = 1'b1;

  adc_control #(.POSITION(241), .CLK_DIV(2)) dut (
    .ebi_clk        (ebi_clk),
    .reset_n        (reset_n),
    .cmd_bus_enable (cmd_bus_enable),
    .re             (re),
    .cmd_bus_wr     (cmd_bus_wr),
    .cmd_bus_addr   (cmd_bus_addr),
    .cmd_bus_data   (cmd_bus_data),
    .out_data       (out_data),
    .adc_sclk       (adc_sclk),
    .adc_ncs        (adc_ncs),
    .adc_dout       (adc_dout),
    .adc_din        (adc_din)
  );

  always #5 ebi_clk = ~ebi_clk;

  // ADC model: capture DIN on sclk rise, drive next result bit on sclk fall.
  always @(negedge ebi_clk) begin
    prev_sclk <= adc_sclk;
    prev_ncs  <= adc_ncs;
    if (prev_ncs && !adc_ncs) begin
      model_cap   <= '0;
      model_rises <= 0;
      ncs_low_cnt <= 1;
    end else begin
      if (!adc_ncs) ncs_low_cnt <= ncs_low_cnt + 1;
      if (!adc_ncs && !prev_sclk && adc_sclk) begin
        model_cap   <= {model_cap[14:0], adc_dout};
        model_rises <= model_rises + 1;
      end
    end
    if (!adc_ncs && prev_sclk && !adc_sclk && model_rises < 16)
      adc_din <= model_res[15 - model_rises];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ebi_clk);
  endtask

  task automatic bus_write(input logic [7:0] pos, input logic [31:0] data);
    cmd_bus_enable = 1'b1;
    cmd_bus_wr     = 1'b1;
    cmd_bus_addr   = {pos, 8'h00};
    cmd_bus_data   = data;
    @(negedge ebi_clk);
    cmd_bus_enable = 1'b0;
    cmd_bus_wr     = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, input logic [15:0] exp, input string tag);
    cmd_bus_enable = 1'b1;
    re             = 1'b1;
    cmd_bus_addr   = {8'd241, off};
    @(negedge ebi_clk);
    cmd_bus_enable = 1'b0;
    re             = 1'b0;
    check(tag, 32'(out_data), 32'(exp));
  endtask

  // Poll the status register every cycle and count cycles reporting busy.
  task automatic measure_busy(output int busy_cycles);
    bit seen_idle;
    busy_cycles = 0;
    seen_idle = 1'b0;
    cmd_bus_enable = 1'b1;
    re             = 1'b1;
    cmd_bus_addr   = {8'd241, 8'd10};
    for (int i = 0; i < 200 && !seen_idle; i++) begin
      @(negedge ebi_clk);
      if (out_data[0]) busy_cycles++;
      else if (busy_cycles > 0) seen_idle = 1'b1;
    end
    cmd_bus_enable = 1'b0;
    re             = 1'b0;
    tick(1);
  endtask

  initial begin
    int busy_cycles;

    // Reset state
    #22;
    check("rst_ncs",  32'(adc_ncs),  32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_dout", 32'(adc_dout), 32'd0);
    check("rst_out",  32'(out_data), 32'd0);
    @(negedge ebi_clk);
    reset_n = 1'b1;
    tick(1);

    bus_read(8'd9,  16'h0ADC, "id");
    bus_read(8'd10, 16'h0000, "status_idle");
    bus_read(8'd5,  16'h0000, "unmapped_off");
    tick(1);
    check("out_zero_no_read", 32'(out_data), 32'd0);

    // Frame 1: cw 0x8310, ADC returns 0x3A5C
    model_res = 16'h3A5C;
    bus_write(8'd241, 32'h0001_8310);
    measure_busy(busy_cycles);
    check("busy_cycles", 32'(busy_cycles), 32'd70);
    check("ncs_low",     32'(ncs_low_cnt), 32'd66);
    check("sclk_rises",  32'(model_rises), 32'd16);
    check("cw_captured", 32'(model_cap),   32'h8310);
    bus_read(8'd10, 16'h0002, "status_valid");
    bus_read(8'd11, 16'h3A5C, "result1");
    bus_read(8'd10, 16'h0000, "status_cleared");
    bus_read(8'd12, 16'h0001, "count1");

    // Writes that must not start a frame
    bus_write(8'd240, 32'h0001_FFFF);
    tick(4);
    check("other_pos_ncs", 32'(adc_ncs), 32'd1);
    bus_write(8'd241, 32'h0002_1234);
    tick(4);
    check("bad_code_ncs", 32'(adc_ncs), 32'd1);
    bus_read(8'd10, 16'h0000, "bad_code_busy");
    bus_read(8'd12, 16'h0001, "bad_code_count");

    // Frame 2 with a SAMPLE write dropped 10 cycles in
    model_res = 16'hC0F1;
    bus_write(8'd241, 32'h0001_55AA);
    tick(9);
    bus_write(8'd241, 32'h0001_FFFF);
    tick(80);
    check("cw2_captured", 32'(model_cap), 32'h55AA);
    bus_read(8'd11, 16'hC0F1, "result2");
    bus_read(8'd12, 16'h0002, "count2");
`ifdef ADC_OVERRUN_CNT_EN
    bus_read(8'd13, 16'h0001, "overrun1");
`else
    bus_read(8'd13, 16'h0000, "overrun_absent");
`endif
    bus_read(8'd13, 16'h0000, "overrun_cleared");

    // Reset in the middle of SHIFT
    model_res = 16'hFFFF;
    bus_write(8'd241, 32'h0001_0F0F);
    tick(20);
    check("mid_frame_ncs", 32'(adc_ncs), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ncs",  32'(adc_ncs),  32'd1);
    check("async_rst_sclk", 32'(adc_sclk), 32'd1);
    check("async_rst_dout", 32'(adc_dout), 32'd0);
    @(negedge ebi_clk);
    reset_n = 1'b1;
    tick(1);
    bus_read(8'd11, 16'h0000, "abort_result");
    bus_read(8'd12, 16'h0000, "abort_count");
    bus_read(8'd10, 16'h0000, "abort_status");

    // Counter wrap FFFF -> 0000
    force dut.sample_cnt = 16'hFFFF;
    #1;
    release dut.sample_cnt;
    tick(1);
    bus_read(8'd12, 16'hFFFF, "count_preset");
    model_res = 16'h8001;
    bus_write(8'd241, 32'h0001_A5A5);
    tick(80);
    check("cw3_captured", 32'(model_cap), 32'hA5A5);
    bus_read(8'd12, 16'h0000, "count_wrap");
    bus_read(8'd11, 16'h8001, "result3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
